// File: rtl/inst_fetch_buffer.sv
// Four-entry instruction queue between fetch and decode. Presents the oldest
// word to decode as inst_de, or an all-zero nop when empty; flush empties it.
module inst_fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst,
  input  logic             in_adel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      inst_de,
  output logic             out_adel,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  logic [64:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic [64:0]      head;

  // Handshake: a word moves on a rising edge only when valid and ready are
  // both high in that cycle and flush is low. in_ready is a function of count
  // alone, so a full buffer refuses a push even while a pop is in progress.
  assign in_ready  = ~rst & (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Empty queue reads as zero, which decodes as sll $0,$0,0.
  assign head     = out_valid ? mem[rd_ptr] : '0;
  assign out_adel = head[64];
  assign out_pc   = head[63:32];
  assign inst_de  = head[31:0];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_adel, in_pc, in_inst};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed bench for inst_fetch_buffer: a queue-based model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_inst_fetch_buffer;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        in_adel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] inst_de;
  logic        out_adel;
  logic [PTR_W:0] count;

  int checks = 0;
  int errors = 0;
  bit seen_flushed_word = 1'b0;

  // Model: the queue contents in arrival order, {adel, pc, inst}.
  logic [64:0] exp_q[$];

  inst_fetch_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_adel(in_adel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .inst_de(inst_de), .out_adel(out_adel),
    .count(count)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: queue semantics straight from the handshake rules.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
    end else if (flush) begin
      exp_q.delete();
    end else begin
      bit do_push;
      bit do_pop;
      do_push = in_valid && (exp_q.size() < DEPTH);
      do_pop  = out_ready && (exp_q.size() > 0);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({in_adel, in_pc, in_inst});
    end
  end

  // Compare process: every cycle, mid-period.
  always @(negedge clk) begin
    logic [64:0] exp_head;
    exp_head = (exp_q.size() != 0) ? exp_q[0] : 65'd0;
    chk("model_count", 65'(count), 65'(exp_q.size()));
    chk("model_out_valid", 65'(out_valid), 65'(exp_q.size() != 0));
    chk("model_in_ready", 65'(in_ready), 65'(!rst && exp_q.size() < DEPTH));
    chk("model_head", {out_adel, out_pc, inst_de}, exp_head);
    if (inst_de == 32'hAAAAAAAA) seen_flushed_word = 1'b1;
  end

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] pc, input logic [31:0] inst, input logic adel);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      next_cycle();
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_wait: in_ready stuck at 0 for inst %h", inst);
    end
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
    in_adel  = adel;
    next_cycle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    out_ready = 1'b1;
    while (out_valid && budget < 20) begin
      next_cycle();
      budget++;
    end
    if (out_valid) begin
      checks++;
      errors++;
      $display("FAIL drain: queue not empty after %0d cycles", budget);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0; in_adel = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 65'(in_ready), 65'd0);
    chk("reset_out_valid", 65'(out_valid), 65'd0);
    chk("reset_inst_de", 65'(inst_de), 65'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("release_in_ready", 65'(in_ready), 65'd1);
    next_cycle();

    // 1. Fill and drain
    for (int k = 0; k < 4; k++) push_word(32'hBFC00000 + 32'(4 * k), 32'(k + 1), 1'b0);
    @(negedge clk);
    chk("fill_count", 65'(count), 65'd4);
    chk("fill_in_ready", 65'(in_ready), 65'd0);
    chk("fill_head_pc", 65'(out_pc), 65'h0BFC00000);
    next_cycle();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("drain_order", 65'(inst_de), 65'(k + 1));
      next_cycle();
    end
    @(negedge clk);
    chk("drain_empty_inst", 65'(inst_de), 65'd0);
    chk("drain_empty_valid", 65'(out_valid), 65'd0);
    next_cycle();

    // 2. Streaming with wrap-around
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_pc    = 32'h00400000 + 32'(4 * c);
      in_inst  = 32'h24010000 + 32'(c);
      in_adel  = 1'b0;
      if (c > 0) begin
        @(negedge clk);
        chk("stream_count", 65'(count), 65'd1);
        chk("stream_order", 65'(inst_de), 65'(32'h24010000 + 32'(c - 1)));
      end
      next_cycle();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_last", 65'(inst_de), 65'h24010009);
    next_cycle();
    out_ready = 1'b0;
    next_cycle();

    // 3. Full with simultaneous pop
    for (int k = 0; k < 4; k++) push_word(32'h100 + 32'(4 * k), 32'h30 + 32'(k), 1'b0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_pc     = 32'h200;
    in_inst   = 32'h55;
    @(negedge clk);
    chk("full_refuse_ready", 65'(in_ready), 65'd0);
    chk("full_refuse_count", 65'(count), 65'd4);
    next_cycle();
    @(negedge clk);
    chk("full_pop_count", 65'(count), 65'd3);
    chk("full_pop_ready", 65'(in_ready), 65'd1);
    chk("full_pop_head", 65'(inst_de), 65'h31);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_accept_count", 65'(count), 65'd3);
    drain();

    // 4. Flush priority
    for (int k = 0; k < 3; k++) push_word(32'h300 + 32'(4 * k), 32'h40 + 32'(k), 1'b0);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_inst   = 32'hAAAAAAAA;
    out_ready = 1'b1;
    next_cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("flush_count", 65'(count), 65'd0);
    chk("flush_valid", 65'(out_valid), 65'd0);
    chk("flush_inst", 65'(inst_de), 65'd0);
    chk("flush_ready", 65'(in_ready), 65'd1);
    push_word(32'h400, 32'h43, 1'b0);
    @(negedge clk);
    chk("post_flush_push", 65'(inst_de), 65'h43);
    drain();
    chk("flushed_word_absent", 65'(seen_flushed_word), 65'd0);

    // 5. Asynchronous reset mid-traffic
    push_word(32'h500, 32'h51, 1'b0);
    push_word(32'h504, 32'h52, 1'b0);
    @(negedge clk);
    chk("pre_reset_count", 65'(count), 65'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 65'(out_valid), 65'd0);
    chk("async_rst_inst", 65'(inst_de), 65'd0);
    chk("async_rst_ready", 65'(in_ready), 65'd0);
    chk("async_rst_count", 65'(count), 65'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push_word(32'h600, 32'h8C220004, 1'b0);
    @(negedge clk);
    chk("post_rst_head", 65'(inst_de), 65'h8C220004);
    chk("post_rst_count", 65'(count), 65'd1);
    next_cycle();
    @(negedge clk);
    chk("post_rst_alone", 65'(inst_de), 65'd0);
    out_ready = 1'b0;
    next_cycle();

    // 6. Error flag passthrough
    push_word(32'h00000003, 32'h1234, 1'b1);
    push_word(32'h00000100, 32'h5678, 1'b0);
    @(negedge clk);
    chk("adel_head_flag", 65'(out_adel), 65'd1);
    chk("adel_head_pc", 65'(out_pc), 65'd3);
    next_cycle();
    @(negedge clk);
    chk("adel_hold_flag", 65'(out_adel), 65'd1);
    out_ready = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("adel_next_flag", 65'(out_adel), 65'd0);
    chk("adel_next_pc", 65'(out_pc), 65'h100);
    next_cycle();
    @(negedge clk);
    chk("adel_empty_pc", 65'(out_pc), 65'd0);
    out_ready = 1'b0;
    next_cycle();

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_buffer.md
# inst_fetch_buffer

Four-entry instruction queue between the fetch stage and the instruction decoder. It accepts {pc, instruction, fetch-address-error} words from fetch with a valid/ready handshake and presents the oldest entry to decode as `inst_de`. It decouples decode stalls from the instruction-memory pipeline and discards all queued words on a pipeline redirect. When the queue is empty, decode sees an all-zero word, which is a MIPS `sll $0,$0,0` nop.

## Interface
- `DEPTH`, 4: number of entries; must be a power of two and at least 2.
- `PTR_W`, 2: pointer width, log2(DEPTH).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: redirect from branch or exception; empties the queue.
- `in_valid` in 1: fetch presents a word.
- `in_ready` out 1: buffer can accept a word this cycle.
- `in_pc` in 32: PC of the incoming word.
- `in_inst` in 32: incoming instruction.
- `in_adel` in 1: fetch address error for the incoming word.
- `out_valid` out 1: `inst_de` holds a real instruction.
- `out_ready` in 1: decode consumes the head this cycle (that is, not stalled).
- `out_pc` out 32: PC of the head entry.
- `inst_de` out 32: head instruction, fed to the decoder.
- `out_adel` out 1: address-error flag of the head entry.
- `count` out PTR_W+1: current occupancy, 0..DEPTH.

## Operation
Storage and pointers:
- Storage is DEPTH registers of 65 bits.
- `wr_ptr` and `rd_ptr` are PTR_W bits and wrap modulo DEPTH.
- `count` is a separate register.

Handshake signals:
- push = `in_valid & in_ready & ~flush`.
- pop = `out_valid & out_ready & ~flush`.
- `in_ready` = `~rst & (count != DEPTH)`. It depends on `count` only; there is no combinational path from `out_ready`. A full buffer therefore refuses a push even when a pop happens in the same cycle.

Head outputs:
- `out_valid` = `(count != 0)`.
- `out_pc`, `inst_de` and `out_adel` are a mux of the entry at `rd_ptr`.
- When `count == 0`, all three are forced to 0.

Per-edge update:
- Push: write the entry at `wr_ptr`, then `wr_ptr` += 1.
- Pop: `rd_ptr` += 1.
- `count` += push − pop. Simultaneous push and pop leaves `count` unchanged.
- Flush: `wr_ptr`, `rd_ptr` and `count` all become 0. Any same-cycle push or pop is ignored, and entry contents are don't-care.
- Priority order is rst > flush > push/pop.

Ordering:
- Words leave in strict arrival order.
- There is no bypass: a word pushed into an empty buffer appears on `inst_de` in the next cycle.

Reset values (asynchronous):
- Internal state: `wr_ptr` = 0, `rd_ptr` = 0, `count` = 0. Storage is not reset.
- Outputs:
  - `out_valid` = 0
  - `inst_de` = 0
  - `out_pc` = 0
  - `out_adel` = 0
  - `in_ready` = 0 while `rst` is high, then 1 in the first cycle after release.
- Reset in the middle of traffic drops all entries immediately, without waiting for a clock edge.

## Timing
- Push-to-head latency is 1 cycle.
- Pop takes effect at the edge: the next entry, or a nop if the queue is now empty, is visible after the edge.
- Throughput is 1 word per cycle in steady state when `0 < count < DEPTH`.
- With `out_ready` low, the head outputs stay constant.
- Flush asserted in cycle N:
  - `out_valid` = 0 and `inst_de` = 0 in cycle N+1.
  - `in_ready` = 1 in cycle N+1.
  - A push in cycle N+1 is accepted normally.
- Full boundary: from `count == DEPTH`, a pop in cycle N gives `in_ready` = 1 in cycle N+1.
- Wrap-around: pointers roll over from DEPTH−1 to 0 with no bubble.

## Test plan
1. **Fill and drain.** With `out_ready` = 0, push inst 0x00000001..0x00000004 (pc 0xBFC00000 + 4k).
   - `in_ready` = 0 and `count` = 4.
   - Then `out_ready` = 1: the four instructions appear in order on 4 consecutive cycles, followed by `inst_de` = 0 and `out_valid` = 0.
2. **Streaming with wrap-around.** Continuous push and pop of 10 words (0x24010000 + k).
   - `count` stays at 1 after the first cycle.
   - Output order equals input order across two pointer wraps.
3. **Full with simultaneous pop.** At `count` = 4, assert `out_ready` and `in_valid` together.
   - Cycle N: the push is refused.
   - Cycle N+1: `count` = 3 and `in_ready` = 1; the refused word is accepted in N+1.
4. **Flush priority.** At `count` = 3, assert `flush`, `in_valid` (inst 0xAAAAAAAA) and `out_ready` in the same cycle.
   - Next cycle: `count` = 0, `out_valid` = 0, and 0xAAAAAAAA never appears on `inst_de`.
5. **Asynchronous reset mid-traffic.** At `count` = 2, raise `rst` between clock edges.
   - Outputs go to 0 immediately, with `in_ready` = 0.
   - After release, a push of 0x8C220004 appears alone on the next cycle.
6. **Error flag passthrough.** Push `in_adel` = 1 with pc 0x00000003.
   - `out_adel` = 1 and `out_pc` = 0x00000003 only while that entry is at the head.
